// File: rtl/sram_sched_pkg.sv
// Shared types and address helpers for the SRAM bank scheduler.
// Lane and bank count are both NLANE; banks are word-interleaved on addr[1:0].
package sram_sched_pkg;
    localparam int NLANE = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    typedef logic [1:0] lane_id_t;

    function automatic logic [1:0] bank_of(input logic [31:0] a);
        return a[1:0];
    endfunction

    function automatic logic [29:0] row_of(input logic [31:0] a);
        return a[31:2];
    endfunction
endpackage

// File: rtl/bank_grant_picker.sv
// Combinational per-bank grant: lowest pending lane wins each bank.
// With BANK_BROADCAST_EN, pending reads to the granted read's address ride along.
module bank_grant_picker
    import sram_sched_pkg::*;
`ifdef BANK_BROADCAST_EN
    #(parameter int ADDR_W = 14)
`endif
(
    input  logic [NLANE-1:0]             i_pend,
    input  logic [NLANE-1:0][1:0]        i_bank,
`ifdef BANK_BROADCAST_EN
    input  logic [NLANE-1:0][ADDR_W-1:0] i_addr,
    input  logic [NLANE-1:0]             i_we,
`endif
    output lane_id_t [NLANE-1:0]         o_gnt_lane,
    output logic [NLANE-1:0]             o_gnt_vld,
    output logic [NLANE-1:0]             o_lane_gnt
);
    always_comb begin
        o_gnt_lane = '0;
        o_gnt_vld  = '0;
        // Descending scan so the lowest matching lane is the one left standing.
        for (int b = 0; b < NLANE; b++) begin
            for (int l = NLANE-1; l >= 0; l--) begin
                if (i_pend[l] && i_bank[l] == 2'(b)) begin
                    o_gnt_lane[b] = lane_id_t'(l);
                    o_gnt_vld[b]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_lane_gnt = '0;
        for (int l = 0; l < NLANE; l++) begin
            o_lane_gnt[l] = i_pend[l] && (o_gnt_lane[i_bank[l]] == lane_id_t'(l));
`ifdef BANK_BROADCAST_EN
            if (i_pend[l] && !i_we[l] && !i_we[o_gnt_lane[i_bank[l]]] &&
                i_addr[l] == i_addr[o_gnt_lane[i_bank[l]]])
                o_lane_gnt[l] = 1'b1;
`endif
        end
    end
endmodule

// File: rtl/sram_bank_scheduler.sv
// Schedules a 4-lane warp access onto 4 word-interleaved SRAM banks, serialising
// bank conflicts in lane order. Optional same-address read merging: BANK_BROADCAST_EN.
module sram_bank_scheduler
    import sram_sched_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NLANE-1:0]             req_active,
    input  logic [NLANE-1:0]             req_we,
    input  logic [NLANE-1:0][ADDR_W-1:0] req_addr,
    input  logic [NLANE-1:0][DATA_W-1:0] req_wd,
    output logic                         done,
    output logic [NLANE-1:0][DATA_W-1:0] lane_rd,
    output logic [NLANE-1:0][ADDR_W-3:0] bank_addr,
    output logic [NLANE-1:0]             bank_we,
    output logic [NLANE-1:0][DATA_W-1:0] bank_wd,
    input  logic [NLANE-1:0][DATA_W-1:0] bank_rd
);
    state_t                        r_state;
    logic [NLANE-1:0]              r_pend, r_we, r_rd_lane;
    logic [NLANE-1:0][ADDR_W-1:0]  r_addr;
    logic [NLANE-1:0][DATA_W-1:0]  r_wd, r_lane_rd, r_bank_wd;
    logic [NLANE-1:0][ADDR_W-3:0]  r_bank_addr;
    logic                          r_done;

    logic [NLANE-1:0][1:0]         w_bank;
    logic [NLANE-1:0][ADDR_W-3:0]  w_row;
    lane_id_t [NLANE-1:0]          w_gnt_lane;
    logic [NLANE-1:0]              w_gnt_vld, w_lane_gnt, w_pend_nxt;
    logic                          w_issue;

    always_comb begin
        for (int l = 0; l < NLANE; l++) begin
            w_bank[l] = bank_of(32'(r_addr[l]));
            w_row[l]  = (ADDR_W-2)'(row_of(32'(r_addr[l])));
        end
    end

    bank_grant_picker
`ifdef BANK_BROADCAST_EN
        #(.ADDR_W(ADDR_W))
`endif
    u_pick (
        .i_pend     (r_pend),
        .i_bank     (w_bank),
`ifdef BANK_BROADCAST_EN
        .i_addr     (r_addr),
        .i_we       (r_we),
`endif
        .o_gnt_lane (w_gnt_lane),
        .o_gnt_vld  (w_gnt_vld),
        .o_lane_gnt (w_lane_gnt)
    );

    assign w_issue    = (r_state == ISSUE);
    assign w_pend_nxt = r_pend & ~w_lane_gnt;
    assign req_ready  = (r_state == IDLE);
    assign done       = r_done;
    assign lane_rd    = r_lane_rd;

    // Idle banks keep their last address/data; bank_we follows state, so reset kills it at once.
    always_comb begin
        for (int b = 0; b < NLANE; b++) begin
            bank_addr[b] = r_bank_addr[b];
            bank_wd[b]   = r_bank_wd[b];
            bank_we[b]   = 1'b0;
            if (w_issue && w_gnt_vld[b]) begin
                bank_addr[b] = w_row[w_gnt_lane[b]];
                bank_wd[b]   = r_wd[w_gnt_lane[b]];
                bank_we[b]   = r_we[w_gnt_lane[b]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_we        <= '0;
            r_addr      <= '0;
            r_wd        <= '0;
            r_rd_lane   <= '0;
            r_lane_rd   <= '0;
            r_bank_addr <= '0;
            r_bank_wd   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_rd_lane <= '0;
            // Bank registered its read at the grant edge; data lands one cycle later.
            for (int l = 0; l < NLANE; l++)
                if (r_rd_lane[l]) r_lane_rd[l] <= bank_rd[w_bank[l]];
            case (r_state)
                IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_we    <= req_we;
                    r_wd    <= req_wd;
                    r_pend  <= req_active;
                    r_state <= (req_active != '0) ? ISSUE : DRAIN;
                end
                ISSUE: begin
                    r_pend    <= w_pend_nxt;
                    r_rd_lane <= w_lane_gnt & ~r_we;
                    for (int b = 0; b < NLANE; b++) begin
                        if (w_gnt_vld[b]) begin
                            r_bank_addr[b] <= w_row[w_gnt_lane[b]];
                            r_bank_wd[b]   <= r_wd[w_gnt_lane[b]];
                        end
                    end
                    if (w_pend_nxt == '0) r_state <= DRAIN;
                end
                DRAIN: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
